// File: rtl/boxhead_pkg.sv
// boxhead_pkg: shared types and constants for the pixel write path.
//   arb_state_e : arbiter FSM state (PARK / LOADED)
//   SCREEN_W/H  : visible raster size in pixels
//   PIXEL_W     : colour width in bits
//   COORD_W     : coordinate width for both axes
//   BURST_W     : width of the consecutive-grant counter
package boxhead_pkg;

  typedef enum logic {
    PARK   = 1'b0,
    LOADED = 1'b1
  } arb_state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PIXEL_W  = 16;
  localparam int COORD_W  = 10;
  localparam int BURST_W  = 5;

  // Index width for n requesters; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_write_arbiter_if.sv
// pixel_write_arbiter_if: requester and SRAM program-port bundle.
//   master : requesters + SRAM controller side (drives req/pixel/slot_tick)
//   slave  : arbiter side (drives ack, program_*, busy)
// With PIXEL_ARB_STATS_EN defined the bundle also carries stats_clr,
// idle_slots and write_count.
interface pixel_write_arbiter_if import boxhead_pkg::*; #(
  parameter int NUM_REQ = 3
);

  logic                             slot_tick;
  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ-1:0][COORD_W-1:0]  req_x;
  logic [NUM_REQ-1:0][COORD_W-1:0]  req_y;
  logic [NUM_REQ-1:0][PIXEL_W-1:0]  req_data;
  logic [NUM_REQ-1:0]               ack;
  logic [COORD_W-1:0]               program_x;
  logic [COORD_W-1:0]               program_y;
  logic [PIXEL_W-1:0]               program_data;
  logic                             busy;
`ifdef PIXEL_ARB_STATS_EN
  logic                             stats_clr;
  logic [15:0]                      idle_slots;
  logic [15:0]                      write_count;
`endif

  modport master (
    output slot_tick, req, req_x, req_y, req_data,
`ifdef PIXEL_ARB_STATS_EN
    output stats_clr,
    input  idle_slots, write_count,
`endif
    input  ack, program_x, program_y, program_data, busy
  );

  modport slave (
    input  slot_tick, req, req_x, req_y, req_data,
`ifdef PIXEL_ARB_STATS_EN
    input  stats_clr,
    output idle_slots, write_count,
`endif
    output ack, program_x, program_y, program_data, busy
  );

endinterface

// File: rtl/pixel_write_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner select.
//   i_req        : request vector
//   i_last_grant : most recent grantee; search starts one past it
//   i_exclude    : requesters barred from this arbitration
//   o_winner     : winning index (valid only with o_valid)
//   o_valid      : at least one eligible requester
module rr_picker import boxhead_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int GW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GW-1:0]      i_last_grant,
  input  logic [NUM_REQ-1:0] i_exclude,
  output logic [GW-1:0]      o_winner,
  output logic               o_valid
);

  logic [NUM_REQ-1:0] w_elig;
  int                 w_dist;
  int                 w_best;

  assign w_elig = i_req & ~i_exclude;

  // Each candidate's distance from the slot after last_grant (wrapping);
  // the eligible candidate with the smallest distance wins.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_best   = NUM_REQ;
    w_dist   = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + 2 * NUM_REQ - int'(i_last_grant) - 1) % NUM_REQ;
      if (w_elig[j] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_winner = GW'(j);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: picks one pending pixel write, parks it on the SRAM
// program port, and acks the requester on the next slot_tick.
//   sram_clk : single clock domain
//   reset    : asynchronous, active-high
//   bus      : pixel_write_arbiter_if.slave (requests, ack, program port, busy)
// Optional: define PIXEL_ARB_STATS_EN for idle_slots / write_count counters
// with stats_clr.
//
// state  | meaning
// PARK   | no pixel held; program port shows the off-screen park pixel
// LOADED | one captured pixel waits for slot_tick
module pixel_write_arbiter import boxhead_pkg::*; #(
  parameter int                 NUM_REQ   = 3,
  parameter int                 MAX_BURST = 16,
  parameter logic [COORD_W-1:0] PARK_X    = 10'd1023,
  parameter logic [COORD_W-1:0] PARK_Y    = 10'd511
) (
  input  logic                  sram_clk,
  input  logic                  reset,
  pixel_write_arbiter_if.slave  bus
);

  localparam int                 GW    = idx_width(NUM_REQ);
  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

  arb_state_e         r_state;
  logic [GW-1:0]      r_grant;
  logic [GW-1:0]      r_last_grant;
  logic [BURST_W-1:0] r_burst;
  logic [COORD_W-1:0] r_prog_x;
  logic [COORD_W-1:0] r_prog_y;
  logic [PIXEL_W-1:0] r_prog_data;

  logic               w_any_req;
  logic               w_at_max;
  logic               w_retain;
  logic [NUM_REQ-1:0] w_exclude;
  logic [GW-1:0]      w_pick_idx;
  logic               w_pick_valid;
  logic [GW-1:0]      w_win_idx;
  logic               w_win_valid;
  logic               w_slot_ack;

  assign w_any_req = |bus.req;
  assign w_at_max  = (r_burst >= MAX_B);
  // A full burst benches the current grantee for exactly one arbitration.
  assign w_exclude = w_at_max ? (NUM_REQ'(1) << r_last_grant) : '0;
  // Zero burst count means no live run (after reset or after a bench-out).
  assign w_retain  = (r_burst != '0) && !w_at_max && bus.req[r_last_grant];

  rr_picker #(.NUM_REQ(NUM_REQ), .GW(GW)) u_picker (
    .i_req        (bus.req),
    .i_last_grant (r_last_grant),
    .i_exclude    (w_exclude),
    .o_winner     (w_pick_idx),
    .o_valid      (w_pick_valid)
  );

  assign w_win_idx   = w_retain ? r_last_grant : w_pick_idx;
  assign w_win_valid = w_retain || w_pick_valid;
  assign w_slot_ack  = (r_state == LOADED) && bus.slot_tick;

  always_ff @(posedge sram_clk or posedge reset) begin
    if (reset) begin
      r_state      <= PARK;
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_burst      <= '0;
      r_prog_x     <= PARK_X;
      r_prog_y     <= PARK_Y;
      r_prog_data  <= '0;
    end else begin
      case (r_state)
        PARK: begin
          if (w_any_req) begin
            if (w_at_max) r_burst <= '0;
            if (w_win_valid) begin
              r_state     <= LOADED;
              r_grant     <= w_win_idx;
              r_prog_x    <= bus.req_x[w_win_idx];
              r_prog_y    <= bus.req_y[w_win_idx];
              r_prog_data <= bus.req_data[w_win_idx];
            end
          end
        end
        LOADED: begin
          if (bus.slot_tick) begin
            r_state      <= PARK;
            r_last_grant <= r_grant;
            r_burst      <= (r_grant == r_last_grant) ? r_burst + 1'b1 : BURST_W'(1);
            r_prog_x     <= PARK_X;
            r_prog_y     <= PARK_Y;
            r_prog_data  <= '0;
          end
        end
        default: r_state <= PARK;
      endcase
    end
  end

  assign bus.ack          = w_slot_ack ? (NUM_REQ'(1) << r_grant) : '0;
  assign bus.busy         = (r_state == LOADED);
  assign bus.program_x    = r_prog_x;
  assign bus.program_y    = r_prog_y;
  assign bus.program_data = r_prog_data;

`ifdef PIXEL_ARB_STATS_EN
  logic [15:0] r_idle_slots;
  logic [15:0] r_write_count;

  always_ff @(posedge sram_clk or posedge reset) begin
    if (reset) begin
      r_idle_slots  <= '0;
      r_write_count <= '0;
    end else if (bus.stats_clr) begin
      r_idle_slots  <= '0;
      r_write_count <= '0;
    end else begin
      if ((r_state == PARK) && bus.slot_tick && (r_idle_slots != 16'hFFFF))
        r_idle_slots <= r_idle_slots + 16'd1;
      if (w_slot_ack && (r_write_count != 16'hFFFF))
        r_write_count <= r_write_count + 16'd1;
    end
  end

  assign bus.idle_slots  = r_idle_slots;
  assign bus.write_count = r_write_count;
`endif

endmodule
